wallace_mult_pipe: RTL

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

---
 rtl/wallace_mult_pipe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//
// Purpose:
//   Pipelined WIDTH x WIDTH multiplier. It builds an AND partial-product
//   matrix, reduces it with a Wallace tree of carry-save (full/half adder)
//   layers and finishes with a carry-propagate adder. The pipeline has three
//   register stages:
//     S1 - partial products after the first reduction layer
//     S2 - the two-row (sum, carry) redundant result
//     S3 - the final product on p
//   Each stage carries a valid bit. A full output that is not taken stalls
//   the whole pipeline.
//
// Configuration:
//   `define WALLACE_MULT_SIGNED_EN to enable Baugh-Wooley signed products,
//   selected per transaction by is_signed. Without the macro, is_signed is
//   ignored and every product is unsigned.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset, flushes the pipeline
//   in_valid   in   a/b (and is_signed) are valid this cycle
//   in_ready   out  operands are accepted this cycle (= pipeline advance)
//   a          in   WIDTH-bit multiplicand
//   b          in   WIDTH-bit multiplier
//   is_signed  in   two's-complement operands (signed build only)
//   out_valid  out  p holds a valid product
//   out_ready  in   consumer takes p this cycle
//   p          out  2*WIDTH-bit product
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  // The signed build adds one extra row holding the Baugh-Wooley constants.
`ifdef WALLACE_MULT_SIGNED_EN
  localparam int NROWS = WIDTH + 1;
`else
  localparam int NROWS = WIDTH;
`endif

  typedef logic [PW-1:0]    row_t;
  typedef row_t [NROWS-1:0] mat_t;

  // Rows left after one carry-save layer: every group of three rows becomes
  // two, the remaining one or two rows pass straight through.
  function automatic int csa_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  localparam int S1_ROWS = csa_rows(NROWS);

  // One Wallace layer over the first n rows of m. Each bit position of a
  // three-row group is a full adder; where a column holds fewer live bits
  // the constant-zero inputs collapse it to a half adder or a wire.
  // Rows at index >= n are zero on entry and stay zero.
  function automatic mat_t csa_layer(input mat_t m, input int n);
    mat_t r;
    int   g;
    r = '0;
    g = n / 3;
    for (int k = 0; k < NROWS / 3; k++) begin
      if (k < g) begin
        r[2*k]   = m[3*k] ^ m[3*k+1] ^ m[3*k+2];
        r[2*k+1] = ((m[3*k] & m[3*k+1]) |
                    (m[3*k] & m[3*k+2]) |
                    (m[3*k+1] & m[3*k+2])) << 1;
      end
    end
    // Leftover rows slide down to sit right after the new sum/carry pairs.
    for (int s = 0; s < NROWS; s++) begin
      if (s >= 3 * g && s < n) begin
        r[s-g] = m[s];
      end
    end
    return r;
  endfunction

  // Remaining Wallace layers from the S1 row count down to two rows.
  // The layer count is fixed by WIDTH, so this unrolls to pure logic.
  function automatic logic [2*PW-1:0] reduce_to_two(input mat_t m);
    mat_t r;
    int   n;
    r = m;
    n = S1_ROWS;
    for (int l = 0; l < NROWS; l++) begin
      if (n > 2) begin
        r = csa_layer(r, n);
        n = csa_rows(n);
      end
    end
    return {r[1], r[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Mode select. is_signed travels with a and b into the partial-product
  // logic, which is captured in S1 on the same edge as the operands.
  // ---------------------------------------------------------------------------
  logic sgn;
`ifdef WALLACE_MULT_SIGNED_EN
  assign sgn = is_signed;
`else
  logic unused_is_signed;
  assign sgn              = 1'b0;
  assign unused_is_signed = is_signed;
`endif

  // ---------------------------------------------------------------------------
  // Partial products. In signed mode (Baugh-Wooley) the terms that mix one
  // sign bit with one magnitude bit are inverted; the sign x sign term is not.
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  mat_t pp;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] bits;
    if (gi == WIDTH - 1) begin : g_sign_row
      assign inv_mask = sgn ? ~MSB_ONLY : '0;
    end else begin : g_mag_row
      assign inv_mask = sgn ? MSB_ONLY : '0;
    end
    assign bits   = (a & {WIDTH{b[gi]}}) ^ inv_mask;
    assign pp[gi] = row_t'(bits) << gi;
  end

`ifdef WALLACE_MULT_SIGNED_EN
  // Correction constants 2^WIDTH + 2^(2*WIDTH-1) that complete the
  // two's-complement negation of the inverted terms.
  assign pp[WIDTH] = sgn ? ((row_t'(1) << WIDTH) | (row_t'(1) << (PW - 1))) : '0;
`endif

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  mat_t            s1_next;
  logic [2*PW-1:0] s2_next;
  row_t            p_next;

  logic            v1_reg;
  logic            v2_reg;
  logic            v3_reg;
  mat_t            s1_reg;
  row_t            s2_sum_reg;
  row_t            s2_carry_reg;
  row_t            p_reg;
  logic            adv;

  assign s1_next = csa_layer(pp, NROWS);
  assign s2_next = reduce_to_two(s1_reg);
  assign p_next  = s2_sum_reg + s2_carry_reg;

  // Only an occupied, untaken output blocks the pipe; bubbles still move.
  assign adv       = !(v3_reg && !out_ready);
  assign in_ready  = adv;
  assign out_valid = v3_reg;
  assign p         = p_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      v3_reg       <= 1'b0;
      s1_reg       <= '0;
      s2_sum_reg   <= '0;
      s2_carry_reg <= '0;
      p_reg        <= '0;
    end else if (adv) begin
      // in_ready equals adv, so in_valid alone marks an accepted transfer.
      v1_reg       <= in_valid;
      s1_reg       <= s1_next;
      v2_reg       <= v1_reg;
      s2_sum_reg   <= s2_next[PW-1:0];
      s2_carry_reg <= s2_next[2*PW-1:PW];
      v3_reg       <= v2_reg;
      p_reg        <= p_next;
    end
  end

endmodule
